// File: rtl/s3_pkg.sv
// Shared S3 definitions for the packer/unpacker pair: trit encoding, polynomial sizes
// and the unpacker state encoding.
package s3_pkg;

    localparam int S3_N_BYTES = 140;
    localparam int S3_N_TRITS = 5 * S3_N_BYTES;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0 = 2'b00;
    localparam trit_t TRIT_1 = 2'b01;
    localparam trit_t TRIT_2 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DIGIT = 2'd2,
        ST_DONE  = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/u8_div3.sv
// Combinational 8-bit divide/modulo by 3 using a reciprocal multiply:
// q = (v*171)>>9 is exact for every 8-bit v, and r = v - 3q.
module u8_div3 (
    input  logic [7:0] v,
    output logic [6:0] q,
    output logic [1:0] r
);

    logic [15:0] prod;
    logic [7:0]  q3;

    assign prod = {8'd0, v} * 16'd171;
    assign q    = prod[15:9];
    // 3q <= 255 for every 8-bit v, so 8 bits cannot overflow
    assign q3   = {1'b0, q} + {q, 1'b0};
    assign r    = 2'(v - q3);

endmodule

// File: rtl/unpack_s3.sv
// Iterative S3 unpacker: expands N_BYTES packed bytes into 5*N_BYTES trits, one byte per
// 6 clocks. Define UNPACK_S3_CHECK_EN to flag bytes >= 243 on the sticky err output.
module unpack_s3
    import s3_pkg::*;
#(
    parameter int N_BYTES = S3_N_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*N_BYTES-1:0]    a,
    output logic [10*N_BYTES-1:0]   out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    unpack_state_t          state;
    logic [8*N_BYTES-1:0]   shadow;
    logic [7:0]             work;
    logic [2:0]             d_cnt;
    logic [KW-1:0]          k_cnt;
    logic [6:0]             div_q;
    trit_t                  div_r;
    logic                   accept;
    logic                   last_digit;
    logic                   last_byte;

    u8_div3 u_div3 (
        .v (work),
        .q (div_q),
        .r (div_r)
    );

    assign accept     = start && (state == ST_IDLE || state == ST_DONE);
    assign last_digit = (d_cnt == 3'd4);
    assign last_byte  = (k_cnt == KW'(N_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            shadow <= '0;
            work   <= '0;
            d_cnt  <= '0;
            k_cnt  <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        shadow <= a;
                        out    <= '0;
                        k_cnt  <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    work  <= shadow[7:0];
                    d_cnt <= '0;
                    state <= ST_DIGIT;
                end
                ST_DIGIT: begin
                    // Trit d of byte k is the d-th base-3 digit, least significant first
                    out[10*int'(k_cnt) + 2*int'(d_cnt) +: 2] <= div_r;
                    work  <= {1'b0, div_q};
                    d_cnt <= d_cnt + 3'd1;
                    if (last_digit) begin
                        if (last_byte) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            shadow <= {8'd0, shadow[8*N_BYTES-1:8]};
                            k_cnt  <= k_cnt + KW'(1);
                            state  <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UNPACK_S3_CHECK_EN
    logic err_r;

    // A quotient left over after the fifth digit means the byte exceeded 242
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= 1'b0;
        end else if (state == ST_DIGIT && last_digit && div_q != 7'd0) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
